// File: rtl/ppu_requant_pkg.sv
// Shared constants and types for the post-processing requantizer.
// Holds the default geometry, mode encodings, per-mode saturation limits
// and the FSM state type used by ppu_requant.
package ppu_requant_pkg;

  localparam int DEF_VL     = 4;
  localparam int DEF_AD     = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_M      = 4;
  localparam int DEF_N      = 16;
  localparam int DEF_N_TILE = (DEF_M / DEF_VL) * (DEF_N / DEF_AD);

  localparam logic [1:0] MODE_INT8     = 2'd0;
  localparam logic [1:0] MODE_INT4     = 2'd1;
  localparam logic [1:0] MODE_INT4_VSQ = 2'd2;

  localparam logic [7:0] QMAX_INT8 = 8'd127;
  localparam logic [7:0] QMAX_INT4 = 8'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX_WAIT,
    S_MAX_CAP,
    S_CALC_WAIT,
    S_CALC_CAP
  } state_e;

  // Positive saturation limit of the output lane for a given mode.
  // The unused encoding behaves like INT8.
  function automatic logic [7:0] qmax_of(input logic [1:0] mode);
    return (mode == MODE_INT4 || mode == MODE_INT4_VSQ) ? QMAX_INT4 : QMAX_INT8;
  endfunction

endpackage

// File: rtl/ppu_shift_calc.sv
// Combinational shift selection: the smallest right shift that brings the
// matrix-wide max magnitude down to the mode's saturation limit.
module ppu_shift_calc
  import ppu_requant_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SW    = $clog2(DEF_ACC_W)
) (
  input  logic [ACC_W-1:0] max_val,
  input  logic [7:0]       qmax,
  output logic [SW-1:0]    shift
);

  // Scan from the widest shift down so the smallest fitting shift wins.
  always_comb begin
    shift = SW'(ACC_W - 1);
    for (int s = ACC_W - 1; s >= 0; s--) begin
      if ((max_val >> s) <= ACC_W'(qmax)) begin
        shift = SW'(s);
      end
    end
  end

endmodule

// File: rtl/ppu_requant.sv
// Post-processing unit fed by the matrix-multiply controller.
// INT8/INT4 run a max pass (track max |acc|) then a calc pass (requantize
// and write); INT4_VSQ runs only the calc pass with a fixed shift.
// Optional feature macro: PPU_RELU_EN clamps negative calc results to 0.
//
// state       | meaning
// ------------+------------------------------------------------------
// S_IDLE      | no matrix in flight, waiting for the first start
// S_MAX_WAIT  | max pass, between tiles
// S_MAX_CAP   | max pass, capturing AD columns of a tile
// S_CALC_WAIT | calc pass, between tiles (first start latches shift)
// S_CALC_CAP  | calc pass, capturing AD columns and writing them out
module ppu_requant
  import ppu_requant_pkg::*;
#(
  parameter int VL        = DEF_VL,
  parameter int AD        = DEF_AD,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int N_TILE    = DEF_N_TILE,
  parameter int VSQ_SHIFT = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [ACC_W*VL-1:0]   i_acc_data,
  output logic                  o_out_we,
  output logic [15:0]           o_out_addr,
  output logic [OUT_W*VL-1:0]   o_out_data,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int SW = $clog2(ACC_W);
  localparam int TW = (N_TILE > 1) ? $clog2(N_TILE) : 1;
  localparam int CW = (AD > 1) ? $clog2(AD) : 1;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [SW-1:0]   shift_q, shift_d, calc_shift;
  logic [TW-1:0]   tile_q, tile_d;
  logic [CW-1:0]   col_q, col_d;
  logic            guard_q, guard_d;
  logic            err_set, max_clr, begin_matrix;
  logic            last_col, last_tile;
  logic [ACC_W-1:0] max_q, max_nxt;

  // Stage 1: raw column plus the context it must be requantized with.
  logic                s1_max, s1_calc, s1_last;
  logic [ACC_W*VL-1:0] s1_data;
  logic [15:0]         s1_addr;
  logic [SW-1:0]       s1_shift;
  logic [7:0]          s1_qmax;

  logic [VL-1:0][ACC_W-1:0] lane_abs;
  logic [VL-1:0][OUT_W-1:0] lane_q;

  assign last_col  = (col_q == CW'(AD - 1));
  assign last_tile = (tile_q == TW'(N_TILE - 1));

  ppu_shift_calc #(.ACC_W(ACC_W), .SW(SW)) u_shift_calc (
    .max_val (max_q),
    .qmax    (qmax_of(mode_q)),
    .shift   (calc_shift)
  );

  // Next-state, counters and protocol error detection.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    shift_d      = shift_q;
    tile_d       = tile_q;
    col_d        = col_q;
    guard_d      = 1'b0;
    err_set      = 1'b0;
    max_clr      = 1'b0;
    begin_matrix = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin_matrix = 1'b1;
      end
      S_MAX_WAIT: begin
        if (i_start) begin
          state_d = S_MAX_CAP;
          col_d   = '0;
        end
      end
      S_CALC_WAIT: begin
        // guard_q marks the cycle right after the last max column: max_r
        // is not final yet, so a start there is a protocol error.
        if (i_start) begin
          if (guard_q) begin
            err_set = 1'b1;
          end else begin
            state_d = S_CALC_CAP;
            col_d   = '0;
            if (tile_q == '0) shift_d = calc_shift;
          end
        end
      end
      S_MAX_CAP: begin
        col_d = col_q + CW'(1);
        if (last_col) begin
          col_d = '0;
          if (last_tile) begin
            tile_d  = '0;
            state_d = S_CALC_WAIT;
            guard_d = 1'b1;
            if (i_start) err_set = 1'b1;
          end else begin
            tile_d  = tile_q + TW'(1);
            state_d = i_start ? S_MAX_CAP : S_MAX_WAIT;
          end
        end else if (i_start) begin
          err_set = 1'b1;
        end
      end
      S_CALC_CAP: begin
        col_d = col_q + CW'(1);
        if (last_col) begin
          col_d = '0;
          if (last_tile) begin
            tile_d  = '0;
            max_clr = 1'b1;
            state_d = S_IDLE;
            if (i_start) begin_matrix = 1'b1;
          end else begin
            tile_d  = tile_q + TW'(1);
            state_d = i_start ? S_CALC_CAP : S_CALC_WAIT;
          end
        end else if (i_start) begin
          err_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (begin_matrix) begin
      mode_d = i_mode;
      col_d  = '0;
      tile_d = '0;
      if (i_mode == MODE_INT4_VSQ) begin
        shift_d = SW'(VSQ_SHIFT);
        state_d = S_CALC_CAP;
      end else begin
        state_d = S_MAX_CAP;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_INT8;
      shift_q <= '0;
      tile_q  <= '0;
      col_q   <= '0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      tile_q  <= tile_d;
      col_q   <= col_d;
      guard_q <= guard_d;
    end
  end

  // Stage 1 capture; shift and limit travel with the data so a new matrix
  // can start on the last column of the previous one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_max   <= 1'b0;
      s1_calc  <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_addr  <= '0;
      s1_shift <= '0;
      s1_qmax  <= '0;
    end else begin
      s1_max   <= (state_q == S_MAX_CAP);
      s1_calc  <= (state_q == S_CALC_CAP);
      s1_last  <= last_tile && last_col;
      s1_data  <= i_acc_data;
      s1_addr  <= 16'(tile_q) * 16'(AD) + 16'(col_q);
      s1_shift <= shift_q;
      s1_qmax  <= qmax_of(mode_q);
    end
  end

  for (genvar g = 0; g < VL; g++) begin : g_lane
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0]   rnd, sum, shr, qpos, qneg;
    logic [OUT_W-1:0]        q;

    assign acc = s1_data[g*ACC_W +: ACC_W];

    // Saturating magnitude: the most negative value maps to the max positive.
    assign lane_abs[g] = (acc == {1'b1, {(ACC_W-1){1'b0}}}) ? {1'b0, {(ACC_W-1){1'b1}}} :
                         (acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc));

    // Round half up, arithmetic shift, clamp to the mode's signed range.
    always_comb begin
      rnd  = (s1_shift == '0) ? '0 : ((ACC_W+1)'(1) << (s1_shift - SW'(1)));
      sum  = {acc[ACC_W-1], acc} + rnd;
      shr  = sum >>> s1_shift;
      qpos = (ACC_W+1)'(s1_qmax);
      qneg = ~qpos;
      if (shr > qpos)      q = qpos[OUT_W-1:0];
      else if (shr < qneg) q = qneg[OUT_W-1:0];
      else                 q = shr[OUT_W-1:0];
`ifdef PPU_RELU_EN
      if (q[OUT_W-1]) q = '0;
`endif
    end

    assign lane_q[g] = q;
  end

  // Running max across all lanes of the captured column.
  always_comb begin
    max_nxt = max_q;
    for (int g = 0; g < VL; g++) begin
      if (lane_abs[g] > max_nxt) max_nxt = lane_abs[g];
    end
  end

  // Matrix-wide max register, cleared once the calc pass has consumed it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     max_q <= '0;
    else if (max_clr) max_q <= '0;
    else if (s1_max)  max_q <= max_nxt;
  end

  // Output stage: one write per calc column, done on the final one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_we   <= 1'b0;
      o_out_addr <= '0;
      o_out_data <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_out_we   <= s1_calc;
      o_out_addr <= s1_calc ? s1_addr : '0;
      o_out_data <= s1_calc ? lane_q : '0;
      o_done     <= s1_calc && s1_last;
      o_err      <= o_err | err_set;
    end
  end

endmodule

// File: tb/tb_ppu_requant.sv
// Self-checking bench for ppu_requant: randomized matrices compared against
// an arithmetic reference model, plus directed protocol corner cases.
module tb_ppu_requant;
  import ppu_requant_pkg::*;

  localparam int VL        = DEF_VL;
  localparam int AD        = DEF_AD;
  localparam int ACC_W     = DEF_ACC_W;
  localparam int OUT_W     = DEF_OUT_W;
  localparam int N_TILE    = DEF_N_TILE;
  localparam int VSQ_SHIFT = 0;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic                i_start;
  logic [1:0]          i_mode;
  logic [ACC_W*VL-1:0] i_acc_data;
  logic                o_out_we;
  logic [15:0]         o_out_addr;
  logic [OUT_W*VL-1:0] o_out_data;
  logic                o_done;
  logic                o_err;

  ppu_requant #(
    .VL(VL), .AD(AD), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .N_TILE(N_TILE), .VSQ_SHIFT(VSQ_SHIFT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_acc_data (i_acc_data),
    .o_out_we   (o_out_we),
    .o_out_addr (o_out_addr),
    .o_out_data (o_out_data),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int                  addr;
    logic [OUT_W*VL-1:0] data;
    logic                done;
    int                  cyc;
  } wr_t;

  wr_t cap_q[$];
  wr_t exp_q[$];

  // Record every write seen on the output port, away from the clock edge.
  always @(negedge i_clk) begin
    if (o_out_we === 1'b1) begin
      wr_t w;
      w.addr = int'(o_out_addr);
      w.data = o_out_data;
      w.done = o_done;
      w.cyc  = cyc;
      cap_q.push_back(w);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int t_first  = 0;
  int mx_d [N_TILE][AD][VL];
  int cl_d [N_TILE][AD][VL];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      i_start    = 1'b0;
      i_acc_data = '0;
    end
  endtask

  // Start a tile in the current cycle and drive its AD columns; returns in
  // the last column's cycle so the caller may start the next tile there.
  task automatic send_tile(input bit calc, input int t, input logic [1:0] m, input int glitch_col);
    i_start = 1'b1;
    i_mode  = m;
    if (calc && t == 0) t_first = cyc;
    step();
    i_start = 1'b0;
    for (int c = 0; c < AD; c++) begin
      for (int g = 0; g < VL; g++)
        i_acc_data[g*ACC_W +: ACC_W] = ACC_W'(calc ? cl_d[t][c][g] : mx_d[t][c][g]);
      i_start = (c == glitch_col);
      if (c < AD - 1) step();
    end
    i_start = 1'b0;
  endtask

  task automatic fill(input bit calc, input int lo, input int hi);
    for (int t = 0; t < N_TILE; t++)
      for (int c = 0; c < AD; c++)
        for (int g = 0; g < VL; g++) begin
          if (calc) cl_d[t][c][g] = int'($urandom_range(hi - lo)) + lo;
          else      mx_d[t][c][g] = int'($urandom_range(hi - lo)) + lo;
        end
  endtask

  function automatic int mag(input int a);
    if (a == -(1 << (ACC_W - 1))) return (1 << (ACC_W - 1)) - 1;
    return (a < 0) ? -a : a;
  endfunction

  // Result of dividing by 2^s with the half added first, using true floor.
  function automatic int model_rq(input int acc, input int s, input int qmax);
    int d, num, r;
    d   = 1 << s;
    num = acc + d / 2;
    r   = (num >= 0) ? num / d : -((-num + d - 1) / d);
    if (r > qmax) r = qmax;
    if (r < -(qmax + 1)) r = -(qmax + 1);
`ifdef PPU_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic build_expected(input logic [1:0] m);
    int qmax, s, mx;
    wr_t w;
    qmax = (m == MODE_INT8) ? 127 : 7;
    if (m == MODE_INT4_VSQ) begin
      s = VSQ_SHIFT;
    end else begin
      mx = 0;
      for (int t = 0; t < N_TILE; t++)
        for (int c = 0; c < AD; c++)
          for (int g = 0; g < VL; g++)
            if (mag(mx_d[t][c][g]) > mx) mx = mag(mx_d[t][c][g]);
      s = 0;
      while ((mx >> s) > qmax) s++;
    end
    exp_q.delete();
    for (int t = 0; t < N_TILE; t++)
      for (int c = 0; c < AD; c++) begin
        w.addr = t * AD + c;
        w.data = '0;
        for (int g = 0; g < VL; g++)
          w.data[g*OUT_W +: OUT_W] = OUT_W'(model_rq(cl_d[t][c][g], s, qmax));
        w.done = (t == N_TILE - 1) && (c == AD - 1);
        w.cyc  = 0;
        exp_q.push_back(w);
      end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, ".count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    if (n > 0) check({tag, ".latency"}, 64'(cap_q[0].cyc), 64'(t_first + 3));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr[%0d]", tag, i), 64'(cap_q[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s.data[%0d]", tag, i), 64'(cap_q[i].data), 64'(exp_q[i].data));
      check($sformatf("%s.done[%0d]", tag, i), 64'(cap_q[i].done), 64'(exp_q[i].done));
      check($sformatf("%s.gapless[%0d]", tag, i), 64'(cap_q[i].cyc), 64'(cap_q[0].cyc + i));
    end
  endtask

  // early: issue a calc start one cycle after the last max column.
  // glitch: column index during the first calc tile where a stray start occurs.
  task automatic run_matrix(input logic [1:0] m, input string tag, input bit early, input int glitch);
    cap_q.delete();
    build_expected(m);
    if (m != MODE_INT4_VSQ) begin
      for (int t = 0; t < N_TILE; t++) send_tile(1'b0, t, m, -1);
      if (early) begin
        idle(1);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check({tag, ".early_err"}, 64'(o_err), 64'd1);
      end else begin
        idle(2);
      end
    end
    for (int t = 0; t < N_TILE; t++) send_tile(1'b1, t, m, (t == 0) ? glitch : -1);
    idle(6);
    compare_writes(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_mode     = MODE_INT8;
    i_acc_data = '0;
    idle(3);
    check("rst.we",   64'(o_out_we),   64'd0);
    check("rst.addr", 64'(o_out_addr), 64'd0);
    check("rst.data", 64'(o_out_data), 64'd0);
    check("rst.done", 64'(o_done),     64'd0);
    check("rst.err",  64'(o_err),      64'd0);
    i_rst_n = 1'b1;
    idle(2);

    // VSQ, shift 0: constant 5 in tile 0, random values that saturate in tile 1.
    for (int c = 0; c < AD; c++)
      for (int g = 0; g < VL; g++) cl_d[0][c][g] = 5;
    for (int t = 1; t < N_TILE; t++)
      for (int c = 0; c < AD; c++)
        for (int g = 0; g < VL; g++) cl_d[t][c][g] = int'($urandom_range(40)) - 20;
    run_matrix(MODE_INT4_VSQ, "vsq", 1'b0, -1);
    check("vsq.first_data", cap_q.size() > 0 ? 64'(cap_q[0].data) : 64'hx, 64'h0505_0505);

    // INT8, max |acc| = 1000 -> shift 3.
    fill(1'b0, -900, 900);
    mx_d[1][3][2] = -1000;
    fill(1'b1, -1000, 1000);
    cl_d[0][0][0] = 1000;
    cl_d[0][0][1] = -1000;
    run_matrix(MODE_INT8, "int8_1000", 1'b0, -1);
    check("int8_1000.pos", cap_q.size() > 0 ? 64'(cap_q[0].data[7:0]) : 64'hx, 64'd125);
`ifdef PPU_RELU_EN
    check("int8_1000.neg", cap_q.size() > 0 ? 64'(cap_q[0].data[15:8]) : 64'hx, 64'h00);
`else
    check("int8_1000.neg", cap_q.size() > 0 ? 64'(cap_q[0].data[15:8]) : 64'hx, 64'h83);
`endif

    // INT8, max 255 -> shift 1; 255 rounds to 128 and saturates to 127.
    fill(1'b0, -200, 200);
    mx_d[0][5][1] = 255;
    fill(1'b1, -300, 300);
    cl_d[0][0][0] = 255;
    run_matrix(MODE_INT8, "int8_255", 1'b0, -1);
    check("int8_255.sat", cap_q.size() > 0 ? 64'(cap_q[0].data[7:0]) : 64'hx, 64'd127);

    // INT4, max 8 -> shift 1; -8 -> -4.
    fill(1'b0, -7, 7);
    mx_d[1][7][3] = -8;
    fill(1'b1, -16, 16);
    cl_d[0][0][0] = -8;
    run_matrix(MODE_INT4, "int4_8", 1'b0, -1);
`ifdef PPU_RELU_EN
    check("int4_8.neg", cap_q.size() > 0 ? 64'(cap_q[0].data[7:0]) : 64'hx, 64'h00);
`else
    check("int4_8.neg", cap_q.size() > 0 ? 64'(cap_q[0].data[7:0]) : 64'hx, 64'hfc);
`endif

    // INT8 with the most negative accumulator in the max pass (abs saturates).
    fill(1'b0, -30000, 30000);
    mx_d[0][0][0] = -(1 << (ACC_W - 1));
    fill(1'b1, -(1 << (ACC_W - 1)), (1 << (ACC_W - 1)) - 1);
    run_matrix(MODE_INT8, "int8_full", 1'b0, -1);
    check("no_err_yet", 64'(o_err), 64'd0);

    // Calc start one cycle too early after the max pass: ignored, error flagged.
    fill(1'b0, -5000, 5000);
    fill(1'b1, -5000, 5000);
    run_matrix(MODE_INT8, "int8_early", 1'b1, -1);

    // Reset in the middle of a calc tile.
    i_start = 1'b1;
    i_mode  = MODE_INT4_VSQ;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_acc_data = {VL{ACC_W'(3)}};
      step();
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst.we",   64'(o_out_we),   64'd0);
    check("midrst.addr", 64'(o_out_addr), 64'd0);
    check("midrst.data", 64'(o_out_data), 64'd0);
    check("midrst.done", 64'(o_done),     64'd0);
    check("midrst.err",  64'(o_err),      64'd0);
    step();
    i_rst_n = 1'b1;
    idle(2);
    fill(1'b1, -12, 12);
    run_matrix(MODE_INT4_VSQ, "after_rst", 1'b0, -1);
    check("after_rst.err", 64'(o_err), 64'd0);

    // Stray start at T+3 inside a tile: ignored, error set, tile still complete.
    fill(1'b1, -12, 12);
    run_matrix(MODE_INT4_VSQ, "glitch", 1'b0, 2);
    check("glitch.err", 64'(o_err), 64'd1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
